// File: rtl/ascii_cmd_pkg.sv
// Shared types and constants for the ASCII command line parser:
// FSM states, command/error codes, ASCII bytes and keyword literals.
package ascii_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEY,
        ST_SEP,
        ST_ARG,
        ST_FLUSH
    } state_e;

    localparam logic [2:0] CMD_NONE = 3'd0;
    localparam logic [2:0] CMD_TIME = 3'd1;
    localparam logic [2:0] CMD_STAT = 3'd2;
    localparam logic [2:0] CMD_SR04 = 3'd3;
    localparam logic [2:0] CMD_TEMP = 3'd4;
    localparam logic [2:0] CMD_SETT = 3'd5;
    localparam logic [2:0] CMD_MODE = 3'd6;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_KEYWORD = 3'd1;
    localparam logic [2:0] ERR_FORMAT  = 3'd2;
    localparam logic [2:0] ERR_LONG    = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT = 3'd4;
    localparam logic [2:0] ERR_OVERRUN = 3'd5;

    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_COLON = 8'h3A;
    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_3     = 8'h33;
    localparam logic [7:0] CH_9     = 8'h39;
    localparam logic [7:0] CH_LC_A  = 8'h61;
    localparam logic [7:0] CH_LC_Z  = 8'h7A;

    localparam logic [31:0] KW_TIME = "TIME";
    localparam logic [31:0] KW_STAT = "STAT";
    localparam logic [31:0] KW_SR04 = "SR04";
    localparam logic [31:0] KW_TEMP = "TEMP";
    localparam logic [31:0] KW_SETT = "SETT";
    localparam logic [31:0] KW_MODE = "MODE";

    function automatic logic [2:0] kw_to_cmd(input logic [31:0] kw);
        case (kw)
            KW_TIME: return CMD_TIME;
            KW_STAT: return CMD_STAT;
            KW_SR04: return CMD_SR04;
            KW_TEMP: return CMD_TEMP;
            KW_SETT: return CMD_SETT;
            KW_MODE: return CMD_MODE;
            default: return CMD_NONE;
        endcase
    endfunction

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= CH_0) && (c <= CH_9);
    endfunction

endpackage

// File: rtl/ascii_cmd_parser_rx_idle_timer.sv
// Inter-byte idle timer: counts idle cycles while enabled, restarts on clear,
// and flags expiry once TIMEOUT_CYC idle cycles have elapsed (0 disables).
module rx_idle_timer #(
    parameter int unsigned TIMEOUT_CYC = 100000000
) (
    input  logic iClk,
    input  logic iRstn,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (i_clear || !i_enable) begin
            count_d = '0;
        end else if (count_q != LIMIT) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Expiry is not masked by a same-cycle byte: that byte then opens a new line.
    assign o_expire = (TIMEOUT_CYC != 0) && i_enable && (count_q == LIMIT);

endmodule

// File: rtl/ascii_cmd_parser.sv
// CR/LF-terminated ASCII command line parser feeding a one-deep command register.
// Optional ASCII_CMD_CASEFOLD_EN folds 'a'-'z' to uppercase before parsing.
module ascii_cmd_parser
    import ascii_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 100000000,
    parameter int unsigned MAX_LINE    = 16
) (
    input  logic        iClk,
    input  logic        iRstn,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    input  logic        i_cmd_ready,
    output logic        o_cmd_valid,
    output logic [2:0]  o_cmd_code,
    output logic [31:0] o_cmd_arg,
    output logic        o_err_valid,
    output logic [2:0]  o_err_code
);

    localparam int unsigned CW = $clog2(MAX_LINE + 2);
    localparam logic [CW-1:0] CNT_LIM = CW'(MAX_LINE);
    localparam logic [CW-1:0] CNT_SAT = CW'(MAX_LINE + 1);

    state_e      state_q, state_d;
    logic [2:0]  err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [23:0] key_q, key_d;
    logic [2:0]  lcode_q, lcode_d;
    logic [31:0] arg_q, arg_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic [2:0]  cmd_code_q, cmd_code_d;
    logic [31:0] cmd_arg_q, cmd_arg_d;
    logic        err_valid_q, err_valid_d;
    logic [2:0]  err_code_q, err_code_d;

    logic        expire;
    logic [7:0]  ch;

    rx_idle_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_idle_timer (
        .iClk     (iClk),
        .iRstn    (iRstn),
        .i_clear  (i_rx_valid),
        .i_enable (state_q != ST_IDLE),
        .o_expire (expire)
    );

`ifdef ASCII_CMD_CASEFOLD_EN
    always_comb begin
        ch = i_rx_data;
        if (i_rx_data >= CH_LC_A && i_rx_data <= CH_LC_Z) begin
            ch = i_rx_data - 8'h20;
        end
    end
`else
    always_comb begin
        ch = i_rx_data;
    end
`endif

    always_comb begin
        state_e        st;
        logic [2:0]    cur_err;
        logic [CW-1:0] cur_cnt;
        logic [CW-1:0] ai;
        logic [31:0]   key_next;
        logic [2:0]    kc;
        logic [2:0]    chk_err;
        logic [2:0]    line_err;
        logic          is_term;

        // A timeout discards the line; any byte this cycle is parsed as if from IDLE.
        st       = expire ? ST_IDLE : state_q;
        cur_err  = expire ? ERR_NONE : err_q;
        cur_cnt  = expire ? '0 : cnt_q;
        ai       = cur_cnt - CW'(5);
        key_next = {key_q, ch};
        kc       = kw_to_cmd(key_next);
        chk_err  = ERR_NONE;
        line_err = cur_err;
        is_term  = (ch == CH_CR) || (ch == CH_LF);

        state_d     = st;
        err_d       = cur_err;
        cnt_d       = cur_cnt;
        key_d       = key_q;
        lcode_d     = lcode_q;
        arg_d       = arg_q;
        cmd_valid_d = cmd_valid_q && !i_cmd_ready;
        cmd_code_d  = cmd_code_q;
        cmd_arg_d   = cmd_arg_q;
        err_valid_d = expire;
        err_code_d  = expire ? ERR_TIMEOUT : ERR_NONE;

        if (i_rx_valid && is_term) begin
            if (st != ST_IDLE) begin
                if (line_err == ERR_NONE) begin
                    case (st)
                        ST_KEY: line_err = ERR_KEYWORD;
                        ST_SEP: if (lcode_q == CMD_SETT || lcode_q == CMD_MODE) line_err = ERR_FORMAT;
                        ST_ARG: begin
                            if (lcode_q == CMD_SETT && ai != CW'(11)) line_err = ERR_FORMAT;
                            if (lcode_q == CMD_MODE && ai != CW'(1))  line_err = ERR_FORMAT;
                        end
                        default: ;
                    endcase
                end
                if (line_err != ERR_NONE) begin
                    err_valid_d = 1'b1;
                    err_code_d  = line_err;
                end else if (cmd_valid_q && !i_cmd_ready) begin
                    err_valid_d = 1'b1;
                    err_code_d  = ERR_OVERRUN;
                end else begin
                    cmd_valid_d = 1'b1;
                    cmd_code_d  = lcode_q;
                    cmd_arg_d   = arg_q;
                end
                state_d = ST_IDLE;
                err_d   = ERR_NONE;
                cnt_d   = '0;
                arg_d   = '0;
            end
        end else if (i_rx_valid) begin
            if (cur_cnt != CNT_SAT) cnt_d = cur_cnt + 1'b1;
            case (st)
                ST_IDLE: begin
                    key_d   = {16'h0000, ch};
                    arg_d   = '0;
                    lcode_d = CMD_NONE;
                    state_d = ST_KEY;
                end
                ST_KEY: begin
                    key_d = key_next[23:0];
                    if (cur_cnt == CW'(3)) begin
                        if (kc == CMD_NONE) chk_err = ERR_KEYWORD;
                        else begin
                            lcode_d = kc;
                            state_d = ST_SEP;
                        end
                    end
                end
                ST_SEP: begin
                    if (ch == CH_SPACE && (lcode_q == CMD_SETT || lcode_q == CMD_MODE)) state_d = ST_ARG;
                    else chk_err = ERR_FORMAT;
                end
                ST_ARG: begin
                    if (lcode_q == CMD_MODE) begin
                        if (ai != '0 || ch < CH_0 || ch > CH_3) chk_err = ERR_FORMAT;
                        else arg_d = {30'd0, ch[1:0]};
                    end else if (ai > CW'(10)) begin
                        chk_err = ERR_FORMAT;
                    end else if (ai == CW'(2) || ai == CW'(5) || ai == CW'(8)) begin
                        if (ch != CH_COLON) chk_err = ERR_FORMAT;
                    end else if (!is_digit(ch)) begin
                        chk_err = ERR_FORMAT;
                    end else begin
                        arg_d = {arg_q[27:0], ch[3:0]};
                    end
                end
                default: ;
            endcase
            // Overlength outranks a content fault on the same (first excess) char.
            if (cur_err == ERR_NONE) begin
                if (cur_cnt == CNT_LIM) begin
                    err_d   = ERR_LONG;
                    state_d = ST_FLUSH;
                end else if (chk_err != ERR_NONE) begin
                    err_d   = chk_err;
                    state_d = ST_FLUSH;
                end
            end
        end
    end

    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            state_q     <= ST_IDLE;
            err_q       <= ERR_NONE;
            cnt_q       <= '0;
            key_q       <= '0;
            lcode_q     <= CMD_NONE;
            arg_q       <= '0;
            cmd_valid_q <= 1'b0;
            cmd_code_q  <= '0;
            cmd_arg_q   <= '0;
            err_valid_q <= 1'b0;
            err_code_q  <= '0;
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            key_q       <= key_d;
            lcode_q     <= lcode_d;
            arg_q       <= arg_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_code_q  <= cmd_code_d;
            cmd_arg_q   <= cmd_arg_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
        end
    end

    assign o_cmd_valid = cmd_valid_q;
    assign o_cmd_code  = cmd_code_q;
    assign o_cmd_arg   = cmd_arg_q;
    assign o_err_valid = err_valid_q;
    assign o_err_code  = err_code_q;

endmodule
